// File: rtl/ram_port_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ram_port_arbiter                                                          |
// | Round-robin two-requester front end for a simple dual-port RAM with a    |
// | 1-cycle registered read. Define RAM_ARB_CLEAR_EN for the post-reset      |
// | clear sweep.                                                             |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module ram_port_arbiter #(
  parameter int                    DATA_WIDTH  = 8,
  parameter int                    ADDR_WIDTH  = 6,
  parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  m0_req,
  input  logic                  m0_we,
  input  logic [ADDR_WIDTH-1:0] m0_addr,
  input  logic [DATA_WIDTH-1:0] m0_wdata,
  output logic                  m0_gnt,
  output logic                  m0_rvalid,
  output logic [DATA_WIDTH-1:0] m0_rdata,
  input  logic                  m1_req,
  input  logic                  m1_we,
  input  logic [ADDR_WIDTH-1:0] m1_addr,
  input  logic [DATA_WIDTH-1:0] m1_wdata,
  output logic                  m1_gnt,
  output logic                  m1_rvalid,
  output logic [DATA_WIDTH-1:0] m1_rdata,
  output logic                  busy,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_write_addr,
  output logic [ADDR_WIDTH-1:0] ram_read_addr,
  output logic [DATA_WIDTH-1:0] ram_data,
  input  logic [DATA_WIDTH-1:0] ram_q
);

  logic                  serve;
  logic                  last_gnt;
  logic                  rvalid0_q;
  logic                  rvalid1_q;
  logic [ADDR_WIDTH-1:0] read_addr_q;
  logic                  sel_we;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;
  logic                  any_gnt;
  logic                  issue_rd;

`ifdef RAM_ARB_CLEAR_EN
  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_SERVE = 1'b1
  } state_t;

  state_t                state;
  state_t                state_nxt;
  logic [ADDR_WIDTH-1:0] clr_cnt;
  logic                  busy_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_CLEAR;
      clr_cnt <= '0;
      busy_q  <= 1'b1;
    end else begin
      state  <= state_nxt;
      busy_q <= (state_nxt == ST_CLEAR);
      if (state == ST_CLEAR) begin
        clr_cnt <= clr_cnt + 1'b1;
      end
    end
  end

  // Leaving CLEAR is one-way; the counter may wrap afterwards without effect.
  always_comb begin
    state_nxt = state;
    if ((state == ST_CLEAR) && (&clr_cnt)) begin
      state_nxt = ST_SERVE;
    end
  end

  assign serve = (state == ST_SERVE);
  assign busy  = busy_q;
`else
  logic unused_clear_value;

  assign unused_clear_value = ^CLEAR_VALUE;
  assign serve              = 1'b1;
  assign busy               = 1'b0;
`endif

  // last_gnt = 1 means requester 1 won most recently, so requester 0 wins the next tie.
  always_comb begin
    m0_gnt = 1'b0;
    m1_gnt = 1'b0;
    if (serve) begin
      if (m0_req && m1_req) begin
        m0_gnt = last_gnt;
        m1_gnt = ~last_gnt;
      end else begin
        m0_gnt = m0_req;
        m1_gnt = m1_req;
      end
    end
  end

  assign sel_we    = m1_gnt ? m1_we    : m0_we;
  assign sel_addr  = m1_gnt ? m1_addr  : m0_addr;
  assign sel_wdata = m1_gnt ? m1_wdata : m0_wdata;
  assign any_gnt   = m0_gnt | m1_gnt;
  assign issue_rd  = any_gnt & ~sel_we;

  always_comb begin
    ram_we         = any_gnt & sel_we;
    ram_write_addr = sel_addr;
    ram_data       = sel_wdata;
`ifdef RAM_ARB_CLEAR_EN
    if (!serve) begin
      ram_we         = 1'b1;
      ram_write_addr = clr_cnt;
      ram_data       = CLEAR_VALUE;
    end
`endif
  end

  assign ram_read_addr = issue_rd ? sel_addr : read_addr_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      last_gnt    <= 1'b1;
      rvalid0_q   <= 1'b0;
      rvalid1_q   <= 1'b0;
      read_addr_q <= '0;
    end else begin
      rvalid0_q <= issue_rd & m0_gnt;
      rvalid1_q <= issue_rd & m1_gnt;
      if (any_gnt) begin
        last_gnt <= m1_gnt;
      end
      if (issue_rd) begin
        read_addr_q <= sel_addr;
      end
    end
  end

  assign m0_rvalid = rvalid0_q;
  assign m1_rvalid = rvalid1_q;
  assign m0_rdata  = ram_q;
  assign m1_rdata  = ram_q;

endmodule
`default_nettype wire

// File: tb/tb_ram_port_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_ram_port_arbiter                                                       |
// | Self-checking bench: vector table, corner sequences and random traffic   |
// | against a transaction-level reference model. Rev 1.0                     |
// +--------------------------------------------------------------------------+
module tb_ram_port_arbiter;
  localparam int         DW    = 8;
  localparam int         AW    = 6;
  localparam int         DEPTH = 64;
  localparam logic [7:0] CLR   = 8'h00;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          m0_req = 0, m0_we = 0, m1_req = 0, m1_we = 0;
  logic [AW-1:0] m0_addr = '0, m1_addr = '0;
  logic [DW-1:0] m0_wdata = '0, m1_wdata = '0;
  logic          m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, busy, ram_we;
  logic [DW-1:0] m0_rdata, m1_rdata, ram_data, ram_q;
  logic [AW-1:0] ram_write_addr, ram_read_addr;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ram_port_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CLEAR_VALUE(CLR)) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .busy(busy), .ram_we(ram_we), .ram_write_addr(ram_write_addr),
    .ram_read_addr(ram_read_addr), .ram_data(ram_data), .ram_q(ram_q)
  );

  // RAM instance behind the arbiter: one write port, registered read
  logic [DW-1:0] ram [DEPTH];
  always @(posedge clk) begin
    if (ram_we) ram[ram_write_addr] <= ram_data;
    ram_q <= ram[ram_read_addr];
  end

  // Reference model state
  int            clear_left;
  logic          ref_last;
  logic [DW-1:0] ref_mem [DEPTH];
  logic          exp_rv0, exp_rv1;
  logic [DW-1:0] exp_rd;
  logic [AW-1:0] ref_raddr;
  bit            raddr_known;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
`ifdef RAM_ARB_CLEAR_EN
    clear_left = DEPTH;
`else
    clear_left = 0;
`endif
    ref_last    = 1'b1;
    exp_rv0     = 1'b0;
    exp_rv1     = 1'b0;
    raddr_known = 1'b0;
  endtask

  task automatic do_reset(input int n, input logic rd0);
    reset   = 1'b1;
    m0_req  = rd0; m0_we = 1'b0; m0_addr = 6'h03;
    m1_req  = 1'b0;
    repeat (n) @(posedge clk);
    #1;
    reset  = 1'b0;
    m0_req = 1'b0;
    model_reset();
  endtask

  // One clock: drive, check against the model, advance the model.
  task automatic cycle(input logic r0, input logic w0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                       input logic r1, input logic w1, input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                       output logic pg0, output logic pg1, output logic ag0);
    logic eg0, eg1, gw, clr;
    logic [AW-1:0] ga;
    logic [DW-1:0] gd;
    m0_req = r0; m0_we = w0; m0_addr = a0; m0_wdata = d0;
    m1_req = r1; m1_we = w1; m1_addr = a1; m1_wdata = d1;
    #3;
    clr = (clear_left > 0);
    if (clr)           begin eg0 = 1'b0; eg1 = 1'b0; end
    else if (r0 && r1) begin eg0 = ref_last; eg1 = ~ref_last; end
    else               begin eg0 = r0; eg1 = r1; end
    gw = eg1 ? w1 : w0;
    ga = eg1 ? a1 : a0;
    gd = eg1 ? d1 : d0;
    chk("busy", busy, clr);
    chk("m0_gnt", m0_gnt, eg0);
    chk("m1_gnt", m1_gnt, eg1);
    chk("m0_rvalid", m0_rvalid, exp_rv0);
    chk("m1_rvalid", m1_rvalid, exp_rv1);
    if (exp_rv0) chk("m0_rdata", m0_rdata, exp_rd);
    if (exp_rv1) chk("m1_rdata", m1_rdata, exp_rd);
    if (clr) begin
      chk("clr_we", ram_we, 1);
      chk("clr_addr", ram_write_addr, DEPTH - clear_left);
      chk("clr_data", ram_data, CLR);
    end else if ((eg0 | eg1) && gw) begin
      chk("wr_we", ram_we, 1);
      chk("wr_addr", ram_write_addr, ga);
      chk("wr_data", ram_data, gd);
    end else begin
      chk("idle_we", ram_we, 0);
    end
    if (!clr && (eg0 | eg1) && !gw) chk("rd_addr", ram_read_addr, ga);
    else if (raddr_known)            chk("rd_addr_hold", ram_read_addr, ref_raddr);
    ag0 = m0_gnt;
    exp_rv0 = 1'b0;
    exp_rv1 = 1'b0;
    if (clr) begin
      ref_mem[DEPTH - clear_left] = CLR;
      clear_left--;
    end else if (eg0 | eg1) begin
      ref_last = eg1;
      if (gw) ref_mem[ga] = gd;
      else begin
        exp_rv0 = eg0; exp_rv1 = eg1;
        exp_rd = ref_mem[ga];
        ref_raddr = ga; raddr_known = 1'b1;
      end
    end
    pg0 = eg0; pg1 = eg1;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(output logic pg0, output logic pg1, output logic ag0);
    cycle(0, 0, '0, '0, 0, 0, '0, '0, pg0, pg1, ag0);
  endtask

  typedef struct {
    logic r0, w0; logic [AW-1:0] a0; logic [DW-1:0] d0;
    logic r1, w1; logic [AW-1:0] a1; logic [DW-1:0] d1;
    logic g0, g1, rv0, rv1; logic [DW-1:0] rd;
  } vec_t;

  function automatic vec_t mk(logic r0, logic w0, logic [AW-1:0] a0, logic [DW-1:0] d0,
                              logic r1, logic w1, logic [AW-1:0] a1, logic [DW-1:0] d1,
                              logic g0, logic g1, logic rv0, logic rv1, logic [DW-1:0] rd);
    vec_t v;
    v.r0 = r0; v.w0 = w0; v.a0 = a0; v.d0 = d0;
    v.r1 = r1; v.w1 = w1; v.a1 = a1; v.d1 = d1;
    v.g0 = g0; v.g1 = g1; v.rv0 = rv0; v.rv1 = rv1; v.rd = rd;
    return v;
  endfunction

  initial begin
    vec_t tbl [13];
    logic pg0, pg1, ag0;
    logic p0v, p0w, p1v, p1w;
    logic [AW-1:0] p0a, p1a;
    logic [DW-1:0] p0d, p1d;
    int n;

    for (int i = 0; i < DEPTH; i++) begin
      ram[i]     = 8'(i) ^ 8'h5A;
      ref_mem[i] = 8'(i) ^ 8'h5A;
    end

    // Fresh arbitration state: requester 0 wins the first tie.
    tbl[0]  = mk(1,1,6'h10,8'hA5, 0,0,6'h00,8'h00, 1,0, 0,0, 8'h00);
    tbl[1]  = mk(0,0,6'h00,8'h00, 1,0,6'h10,8'h00, 0,1, 0,0, 8'h00);
    tbl[2]  = mk(0,0,6'h00,8'h00, 0,0,6'h00,8'h00, 0,0, 0,1, 8'hA5);
    tbl[3]  = mk(1,0,6'h10,8'h00, 1,0,6'h10,8'h00, 1,0, 0,0, 8'h00);
    tbl[4]  = mk(1,0,6'h10,8'h00, 1,0,6'h10,8'h00, 0,1, 1,0, 8'hA5);
    tbl[5]  = mk(1,0,6'h10,8'h00, 1,0,6'h10,8'h00, 1,0, 0,1, 8'hA5);
    tbl[6]  = mk(1,0,6'h10,8'h00, 1,0,6'h10,8'h00, 0,1, 1,0, 8'hA5);
    tbl[7]  = mk(0,0,6'h00,8'h00, 0,0,6'h00,8'h00, 0,0, 0,1, 8'hA5);
    tbl[8]  = mk(1,1,6'h21,8'hC3, 1,1,6'h20,8'h3C, 1,0, 0,0, 8'h00);
    tbl[9]  = mk(0,0,6'h00,8'h00, 1,1,6'h20,8'h3C, 0,1, 0,0, 8'h00);
    tbl[10] = mk(1,0,6'h20,8'h00, 1,0,6'h21,8'h00, 1,0, 0,0, 8'h00);
    tbl[11] = mk(0,0,6'h00,8'h00, 1,0,6'h21,8'h00, 0,1, 1,0, 8'h3C);
    tbl[12] = mk(0,0,6'h00,8'h00, 0,0,6'h00,8'h00, 0,0, 0,1, 8'hC3);

    do_reset(2, 1'b0);

`ifdef RAM_ARB_CLEAR_EN
    // Held read of 0x3F is granted only once the 64-cycle sweep is over.
    n = 0;
    do begin
      cycle(1, 0, 6'h3F, '0, 0, 0, '0, '0, pg0, pg1, ag0);
      n++;
    end while (!ag0 && n < 100);
    chk("sweep_len", n, 65);
    idle(pg0, pg1, ag0);
    // Reset at clr_cnt=20 restarts the sweep from address 0.
    do_reset(1, 1'b0);
    repeat (20) idle(pg0, pg1, ag0);
    do_reset(1, 1'b0);
    repeat (65) idle(pg0, pg1, ag0);
`else
    // Read granted during reset yields no rvalid; m1 write granted at once.
    do_reset(1, 1'b1);
    cycle(0, 0, '0, '0, 1, 1, 6'h05, 8'h77, pg0, pg1, ag0);
    cycle(0, 0, '0, '0, 1, 0, 6'h05, 8'h00, pg0, pg1, ag0);
    idle(pg0, pg1, ag0);
`endif

    do_reset(1, 1'b0);
    while (clear_left > 0) idle(pg0, pg1, ag0);

    for (int i = 0; i < 13; i++) begin
      m0_req = tbl[i].r0; m0_we = tbl[i].w0; m0_addr = tbl[i].a0; m0_wdata = tbl[i].d0;
      m1_req = tbl[i].r1; m1_we = tbl[i].w1; m1_addr = tbl[i].a1; m1_wdata = tbl[i].d1;
      #2;
      chk($sformatf("tbl%0d_g0", i), m0_gnt, tbl[i].g0);
      chk($sformatf("tbl%0d_g1", i), m1_gnt, tbl[i].g1);
      chk($sformatf("tbl%0d_rv0", i), m0_rvalid, tbl[i].rv0);
      chk($sformatf("tbl%0d_rv1", i), m1_rvalid, tbl[i].rv1);
      if (tbl[i].rv0) chk($sformatf("tbl%0d_rd0", i), m0_rdata, tbl[i].rd);
      if (tbl[i].rv1) chk($sformatf("tbl%0d_rd1", i), m1_rdata, tbl[i].rd);
      cycle(tbl[i].r0, tbl[i].w0, tbl[i].a0, tbl[i].d0,
            tbl[i].r1, tbl[i].w1, tbl[i].a1, tbl[i].d1, pg0, pg1, ag0);
    end

    // Back-to-back writes then reads of 0x00..0x07 from requester 0
    for (int i = 0; i < 8; i++) cycle(1, 1, 6'(i), 8'h80 + 8'(i), 0, 0, '0, '0, pg0, pg1, ag0);
    for (int i = 0; i < 8; i++) cycle(1, 0, 6'(i), '0, 0, 0, '0, '0, pg0, pg1, ag0);
    idle(pg0, pg1, ag0);

    // Random traffic; each request is held until the model says it was granted.
    p0v = 0; p1v = 0;
    p0w = 0; p1w = 0; p0a = '0; p1a = '0; p0d = '0; p1d = '0;
    for (int c = 0; c < 400; c++) begin
      if (!p0v && ($urandom_range(0, 2) != 0)) begin
        p0v = 1; p0w = 1'($urandom_range(0, 1)); p0a = 6'($urandom_range(0, 15)); p0d = 8'($urandom);
      end
      if (!p1v && ($urandom_range(0, 2) != 0)) begin
        p1v = 1; p1w = 1'($urandom_range(0, 1)); p1a = 6'($urandom_range(0, 15)); p1d = 8'($urandom);
      end
      cycle(p0v, p0w, p0a, p0d, p1v, p1w, p1a, p1d, pg0, pg1, ag0);
      if (pg0) p0v = 0;
      if (pg1) p1v = 0;
    end
    idle(pg0, pg1, ag0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ram_port_arbiter.md
# ram_port_arbiter

Shares the simple dual-port RAM (one write port, one registered read port, 1-cycle read latency) between two requesters, requester 0 and requester 1. The block issues at most one transaction per cycle, either a read or a write. It uses round-robin arbitration and routes read data back to the requester that issued the read. It sits directly in front of the RAM instance, and both requesters see a uniform req/gnt interface. An optional post-reset sweep clears the whole RAM to a known value before any request is served.

## Interface
- DATA_WIDTH, 8, RAM word width.
- ADDR_WIDTH, 6, RAM address width; depth = 2**ADDR_WIDTH.
- CLEAR_VALUE, 0, word written to every location during the clear sweep.

- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- m0_req / m1_req  in  1  transaction request; held with attributes until granted.
- m0_we / m1_we  in  1  1 = write, 0 = read.
- m0_addr / m1_addr  in  ADDR_WIDTH  transaction address.
- m0_wdata / m1_wdata  in  DATA_WIDTH  write data.
- m0_gnt / m1_gnt  out  1  combinational grant; the transaction is issued in the same cycle.
- m0_rvalid / m1_rvalid  out  1  registered; read data valid for this requester.
- m0_rdata / m1_rdata  out  DATA_WIDTH  equal to ram_q; meaningful only while the matching rvalid is high.
- busy  out  1  registered; high during the clear sweep.
- ram_we  out  1  RAM write enable.
- ram_write_addr, ram_read_addr  out  ADDR_WIDTH  RAM addresses.
- ram_data  out  DATA_WIDTH  RAM write data.
- ram_q  in  DATA_WIDTH  RAM registered read output.

## Operation
- States:
  - CLEAR: sweep the RAM.
  - SERVE: arbitrate requests.
- Reset entry:
  - Reset enters CLEAR if the macro is defined, otherwise SERVE.
  - Reset sets clr_cnt=0, last_gnt=1 (requester 0 wins first contention), m0_rvalid=0, m1_rvalid=0.
  - busy resets to 1 with the macro and 0 without it.
- CLEAR:
  - Drives ram_we=1, ram_write_addr=clr_cnt, ram_data=CLEAR_VALUE.
  - Both gnt are 0.
  - clr_cnt increments each cycle.
  - When clr_cnt is all-ones, that write completes and the next state is SERVE, with busy=0 from that cycle on.
  - The counter does not wrap back into CLEAR.
- SERVE arbitration:
  - Only one requester asserting req: that requester is granted.
  - Both asserting req: grant goes to the requester not equal to last_gnt.
  - last_gnt updates to the granted requester on every grant.
  - No req: no grant and ram_we=0.
- Granted write: ram_we=1, ram_write_addr=addr, ram_data=wdata.
- Granted read:
  - ram_read_addr=addr and ram_we=0.
  - The owner is recorded, and that requester's rvalid is 1 in the next cycle.
- ram_read_addr when idle: holds the last value; no rvalid follows.
- Requesters must not derive req from gnt (no combinational loop).
- Write at cycle N followed by a read of the same address at N+1 returns the new data.
- Reset mid-operation:
  - Aborts any sweep; the sweep restarts at address 0 when the macro is defined.
  - A read granted in the reset cycle produces no rvalid.

## Timing
- req→gnt: 0 cycles, combinational.
- Write is committed at the rising edge that ends the grant cycle.
- Read latency: rvalid and rdata appear exactly 1 cycle after gnt.
- Back-to-back grants to either requester are possible every cycle.
- Throughput: one transaction per cycle.
- Clear sweep length: 2**ADDR_WIDTH cycles after reset deasserts (64 at defaults).

## Configuration
- RAM_ARB_CLEAR_EN defined:
  - CLEAR state, clr_cnt and CLEAR_VALUE logic are compiled in.
  - The RAM holds CLEAR_VALUE everywhere before the first grant.
- RAM_ARB_CLEAR_EN undefined:
  - No CLEAR state; busy is tied to 0.
  - Requests are granted in the first cycle after reset.
  - RAM contents are whatever the RAM initialisation file loaded.

## Test plan
- Macro on, defaults, release reset: busy=1 for 64 cycles and no gnt despite m0_req=1. Then gnt on cycle 65; a read of 0x3F returns 0x00 with m0_rvalid.
- Reset pulsed when clr_cnt=20: the sweep restarts from 0, and busy stays high for a further 64 cycles.
- m0 writes 0xA5 to 0x10 at cycle N; m1 reads 0x10 at N+1: m1_rvalid=1 at N+2 with m1_rdata=0xA5, and m0_rvalid stays 0.
- Both requesters hold read requests for 4 cycles: gnt order is m0, m1, m0, m1. The rvalid pulses follow one cycle later to the matching requester.
- m0 issues continuous reads of 0x00..0x07: m0_gnt high for 8 consecutive cycles, then 8 consecutive rvalid cycles with data in address order.
- Macro off: m1 write requested in the first cycle after reset is granted immediately, and busy=0 throughout.
